// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Operands arrive in Montgomery form; a final multiply-by-1 returns to the normal domain.
module mont_exp_ctrl #(
   parameter int N       = 512,
   parameter int E_WIDTH = 512,
   parameter int CNT_W   = 10
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [N-1:0]       in_x,
   input  logic [N-1:0]       in_r,
   input  logic [E_WIDTH-1:0] in_e,
   input  logic [CNT_W-1:0]   in_e_len,
   input  logic [N-1:0]       in_m,
   output logic               mont_start,
   output logic [N-1:0]       mont_a,
   output logic [N-1:0]       mont_b,
   output logic [N-1:0]       mont_m,
   input  logic [N-1:0]       mont_result,
   input  logic               mont_done,
   output logic [N-1:0]       result,
   output logic               done,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, NEXT, POST_START, POST_WAIT
   } state_t;

   state_t             state, state_nxt;
   logic [N-1:0]       a_q, x_q, m_q;
   logic [E_WIDTH-1:0] e_q;
   logic [CNT_W-1:0]   idx_q;
   logic               e_bit;
   logic [N-1:0]       one_n;

   assign one_n = N'(1);

   always_comb begin
      e_bit = 1'b0;
      for (int unsigned i = 0; i < E_WIDTH; i++) begin
         if (idx_q == CNT_W'(i)) e_bit = e_q[i];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // mont_done is only looked at in WAIT states, so a level still high from
   // the previous operation cannot be consumed by a START cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = (in_e_len == '0) ? POST_START : SQ_START;
         SQ_START:   state_nxt = SQ_WAIT;
         SQ_WAIT:    if (mont_done) state_nxt = e_bit ? MUL_START : NEXT;
         MUL_START:  state_nxt = MUL_WAIT;
         MUL_WAIT:   if (mont_done) state_nxt = NEXT;
         NEXT:       state_nxt = (idx_q == '0) ? POST_START : SQ_START;
         POST_START: state_nxt = POST_WAIT;
         POST_WAIT:  if (mont_done) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mont_start = (state == SQ_START) || (state == MUL_START) || (state == POST_START);
      busy       = (state != IDLE);
      mont_a     = '0;
      mont_b     = '0;
      mont_m     = '0;
      case (state)
         SQ_START, SQ_WAIT: begin
            mont_a = a_q;
            mont_b = a_q;
            mont_m = m_q;
         end
         MUL_START, MUL_WAIT: begin
            mont_a = a_q;
            mont_b = x_q;
            mont_m = m_q;
         end
         POST_START, POST_WAIT: begin
            mont_a = a_q;
            mont_b = one_n;
            mont_m = m_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_q    <= '0;
         x_q    <= '0;
         e_q    <= '0;
         m_q    <= '0;
         idx_q  <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               x_q   <= in_x;
               a_q   <= in_r;
               e_q   <= in_e;
               m_q   <= in_m;
               idx_q <= (in_e_len == '0) ? '0 : in_e_len - CNT_W'(1);
            end
            SQ_WAIT, MUL_WAIT: if (mont_done) a_q <= mont_result;
            NEXT: if (idx_q != '0) idx_q <= idx_q - CNT_W'(1);
            POST_WAIT: if (mont_done) begin
               result <= mont_result;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with random latency,
// golden modular exponentiation computed with plain arithmetic.
module tb_mont_exp_ctrl;
   localparam int N       = 512;
   localparam int E_WIDTH = 512;
   localparam int CNT_W   = 10;

   logic               clk      = 1'b0;
   logic               resetn   = 1'b0;
   logic               start    = 1'b0;
   logic [N-1:0]       in_x     = '0;
   logic [N-1:0]       in_r     = '0;
   logic [N-1:0]       in_m     = '0;
   logic [E_WIDTH-1:0] in_e     = '0;
   logic [CNT_W-1:0]   in_e_len = '0;
   logic               mont_start;
   logic [N-1:0]       mont_a, mont_b, mont_m;
   logic [N-1:0]       mont_result = '0;
   logic               mont_done   = 1'b0;
   logic [N-1:0]       result;
   logic               done, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mont_exp_ctrl #(.N(N), .E_WIDTH(E_WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
      .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
      .mont_result(mont_result), .mont_done(mont_done),
      .result(result), .done(done), .busy(busy)
   );

   function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] m);
      logic [2*N+1:0] t, w;
      t = '0; w = '0;
      t[N-1:0] = a;
      w[N-1:0] = b;
      t = t * w;
      w = '0;
      w[N-1:0] = m;
      for (int i = 0; i < N; i++) begin
         if (t[0]) t = t + w;
         t = t >> 1;
      end
      if (t >= w) t = t - w;
      return t[N-1:0];
   endfunction

   function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m);
      logic [2*N-1:0] p, w;
      p = '0; w = '0;
      p[N-1:0] = a;
      w[N-1:0] = b;
      p = p * w;
      w = '0;
      w[N-1:0] = m;
      p = p % w;
      return p[N-1:0];
   endfunction

   function automatic logic [N-1:0] r_mod(input logic [N-1:0] m);
      logic [N:0] t, w;
      t = '0; w = '0;
      t[N] = 1'b1;
      w[N-1:0] = m;
      t = t % w;
      return t[N-1:0];
   endfunction

   // Right-to-left binary exponentiation in the normal domain.
   function automatic logic [N-1:0] modexp(input logic [N-1:0] x, input logic [E_WIDTH-1:0] e,
                                           input int len, input logic [N-1:0] m);
      logic [N-1:0] res, b;
      res  = mulmod(N'(1), N'(1), m);
      b    = mulmod(x, N'(1), m);
      for (int i = 0; i < len; i++) begin
         if (e[i]) res = mulmod(res, b, m);
         b = mulmod(b, b, m);
      end
      return res;
   endfunction

   function automatic logic [N-1:0] rand_n();
      logic [N-1:0] v;
      for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Multiplier model: one operation at a time, random latency, done held hold_cfg cycles.
   int           n_starts    = 0;
   int           stab_err    = 0;
   int           overlap_err = 0;
   int           lat_cnt     = 0;
   int           hold_left   = 0;
   int           hold_cfg    = 1;
   logic         m_busy      = 1'b0;
   logic [N-1:0] cap_a = '0, cap_b = '0, cap_m = '0;
   logic [1:0]   kinds [0:2047];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy    <= 1'b0;
         mont_done <= 1'b0;
         lat_cnt   <= 0;
         hold_left <= 0;
      end else if (mont_start) begin
         if (m_busy) overlap_err <= overlap_err + 1;
         cap_a       <= mont_a;
         cap_b       <= mont_b;
         cap_m       <= mont_m;
         mont_result <= mont_ref(mont_a, mont_b, mont_m);
         kinds[n_starts % 2048] <= (mont_b == N'(1)) ? 2'd3 : (mont_a == mont_b) ? 2'd1 : 2'd2;
         n_starts    <= n_starts + 1;
         lat_cnt     <= int'($urandom_range(40, 1));
         m_busy      <= 1'b1;
         mont_done   <= 1'b0;
      end else if (m_busy) begin
         if (mont_a !== cap_a || mont_b !== cap_b || mont_m !== cap_m) stab_err <= stab_err + 1;
         if (lat_cnt <= 1) begin
            m_busy    <= 1'b0;
            mont_done <= 1'b1;
            hold_left <= hold_cfg;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end else if (mont_done) begin
         if (hold_left <= 1) mont_done <= 1'b0;
         else                hold_left <= hold_left - 1;
      end
   end

   task automatic run_op(input string tag, input logic [N-1:0] x, input logic [E_WIDTH-1:0] e,
                         input int len, input logic [N-1:0] m, input int hold, input bit spam,
                         input logic [N-1:0] prev_res, output logic [N-1:0] got, output int base);
      logic [N-1:0] rm, exp_res;
      int exp_ops, budget, st0, ov0;
      bit seen;
      rm      = r_mod(m);
      exp_res = modexp(x, e, len, m);
      exp_ops = 1 + len;
      for (int i = 0; i < len; i++) exp_ops += int'(e[i]);
      hold_cfg = hold;
      @(negedge clk);
      base = n_starts;
      st0  = stab_err;
      ov0  = overlap_err;
      in_x = mulmod(x, rm, m);
      in_r = rm;
      in_e = e;
      in_e_len = CNT_W'(len);
      in_m = m;
      start = 1'b1;
      @(negedge clk);
      start = spam;
      chk({tag, " busy_after_start"}, N'(busy), N'(1));
      chk({tag, " result_held"}, result, prev_res);
      seen   = 1'b0;
      budget = exp_ops * 45 + len + 20;
      for (int cyc = 0; cyc < budget && !seen; cyc++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (spam) begin
               in_x     = rand_n();
               in_r     = rand_n();
               in_m     = rand_n() | N'(1);
               in_e     = rand_n();
               in_e_len = CNT_W'($urandom_range(E_WIDTH, 0));
               start    = 1'b1;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      got   = result;
      chk({tag, " done_seen"}, N'(seen), N'(1));
      chk({tag, " busy_falls_with_done"}, N'(busy), N'(0));
      chk({tag, " result"}, result, exp_res);
      chk({tag, " op_count"}, N'(n_starts - base), N'(exp_ops));
      chk({tag, " operand_stability"}, N'(stab_err - st0), N'(0));
      chk({tag, " no_overlap"}, N'(overlap_err - ov0), N'(0));
      @(negedge clk);
      chk({tag, " done_one_cycle"}, N'(done), N'(0));
      chk({tag, " result_stays"}, result, exp_res);
      if (!seen) begin
         resetn = 1'b0;
         @(negedge clk);
         resetn = 1'b1;
      end
   endtask

   initial begin
      logic [N-1:0]       m, x, got, prev;
      logic [E_WIDTH-1:0] e;
      logic [31:0]        got_code, exp_code;
      string              seq;
      int                 base, n0;
      bit                 reached;

      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst mont_start", N'(mont_start), N'(0));
      chk("rst busy", N'(busy), N'(0));
      chk("rst done", N'(done), N'(0));
      chk("rst result", result, N'(0));
      chk("rst operands", mont_a | mont_b | mont_m, N'(0));
      resetn = 1'b1;
      @(negedge clk);

      m = N'(13); x = N'(5); e = E_WIDTH'(3);
      run_op("t1_small", x, e, 2, m, 1, 1'b0, N'(0), got, base);
      chk("t1 five_cubed_mod13", got, N'(8));
      prev = got;

      e = rand_n();
      run_op("t2_len0", x, e, 0, m, 1, 1'b0, prev, got, base);
      chk("t2 one_mod_m", got, N'(1));
      prev = got;

      m = rand_n();
      m[0] = 1'b1; m[N-1] = 1'b1;
      x = mulmod(rand_n(), N'(1), m);
      e = E_WIDTH'(11);
      run_op("t3_rand_e11", x, e, 4, m, 1, 1'b0, prev, got, base);
      seq = "SMSSMSMP";
      got_code = '0; exp_code = '0;
      for (int i = 0; i < seq.len(); i++) begin
         exp_code = (exp_code << 2) | ((seq[i] == "S") ? 32'd1 : (seq[i] == "M") ? 32'd2 : 32'd3);
         got_code = (got_code << 2) | 32'(kinds[(base + i) % 2048]);
      end
      chk("t3 op_sequence", N'(got_code), N'(exp_code));
      prev = got;

      x = mulmod(rand_n(), N'(1), m);
      e = '1;
      run_op("t4_full_width", x, e, E_WIDTH, m, 1, 1'b0, prev, got, base);
      prev = got;

      m = rand_n();
      m[0] = 1'b1; m[N-1] = 1'b1;
      x = mulmod(rand_n(), N'(1), m);
      e = E_WIDTH'($urandom_range(255, 128));
      run_op("t5_spam_hold3", x, e, 8, m, 3, 1'b1, prev, got, base);
      prev = got;

      // Abort during MUL_WAIT: second pulse of 5^3 is the first multiply.
      m = N'(13); x = N'(5); e = E_WIDTH'(3);
      hold_cfg = 1;
      @(negedge clk);
      n0       = n_starts;
      in_x     = mulmod(x, r_mod(m), m);
      in_r     = r_mod(m);
      in_e     = e;
      in_e_len = CNT_W'(2);
      in_m     = m;
      start    = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      reached = 1'b0;
      for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
         if (n_starts >= n0 + 2) reached = 1'b1;
         else @(negedge clk);
      end
      chk("t6 reached_mul_wait", N'(reached), N'(1));
      resetn = 1'b0;
      #1;
      chk("t6 abort mont_start", N'(mont_start), N'(0));
      chk("t6 abort busy", N'(busy), N'(0));
      chk("t6 abort done", N'(done), N'(0));
      chk("t6 abort result", result, N'(0));
      chk("t6 abort operands", mont_a | mont_b | mont_m, N'(0));
      n0 = n_starts;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6 no_pulse_after_abort", N'(n_starts - n0), N'(0));
      run_op("t6_after_reset", x, e, 2, m, 1, 1'b0, N'(0), got, base);
      chk("t6 five_cubed_mod13", got, N'(8));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Left-to-right square-and-multiply sequencer for RSA modular exponentiation.
- Acts as the initiator for the existing montgomery multiplier. It drives that block's start/in_a/in_b/in_m and consumes its result/done.
- Operands enter already in the Montgomery domain. One final multiply-by-1 converts the result back to the normal domain.
- Sits between the RSA top/CPU interface and the montgomery instance.

Parameters:
- N, 512, operand/modulus width in bits.
- E_WIDTH, 512, exponent register width in bits.
- CNT_W, 10, width of the bit-index counter; must satisfy 2^CNT_W > E_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; operands sampled on the same edge.
- in_x  in  N  base in Montgomery form, x*R mod M.
- in_r  in  N  R mod M (Montgomery one).
- in_e  in  E_WIDTH  exponent.
- in_e_len  in  CNT_W  number of exponent bits to process, 0..E_WIDTH.
- in_m  in  N  odd modulus M.
- mont_start  out  1  start pulse to the multiplier.
- mont_a  out  N  multiplier operand a.
- mont_b  out  N  multiplier operand b.
- mont_m  out  N  multiplier modulus.
- mont_result  in  N  multiplier result.
- mont_done  in  1  multiplier completion (level).
- result  out  N  x^e mod M, normal domain.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the accepted start until done.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE.
  - mont_start, done, busy = 0.
  - result, mont_a, mont_b, mont_m, internal A/X/E/M registers = 0.
  - Bit index = 0.
- Internal registers: A (accumulator), X, E, M, idx (CNT_W bits).
- IDLE:
  - On start=1: latch X=in_x, A=in_r, E=in_e, M=in_m; set busy=1.
  - If in_e_len=0, go to POST_START. Otherwise idx=in_e_len-1 and go to SQ_START.
  - mont_done is ignored in IDLE.
- SQ_START: mont_a=A, mont_b=A, mont_m=M, mont_start=1 for exactly one cycle, then SQ_WAIT.
- SQ_WAIT:
  - mont_start=0; operands held stable.
  - On mont_done=1: A<=mont_result. If E[idx]=1 go to MUL_START, else go to NEXT.
- MUL_START: mont_a=A, mont_b=X, mont_start=1 for one cycle, then MUL_WAIT.
- MUL_WAIT: on mont_done=1, A<=mont_result, then NEXT.
- NEXT:
  - If idx=0, go to POST_START.
  - Otherwise idx<=idx-1 and go to SQ_START.
- POST_START: mont_a=A, mont_b=1 (zero-extended to N), mont_start=1 for one cycle, then POST_WAIT.
- POST_WAIT: on mont_done=1: result<=mont_result, done=1 for one cycle, busy=0, back to IDLE.
- Handshake rules:
  - Operands on mont_a/b/m stay stable from the mont_start cycle until the cycle mont_done is sampled high.
  - mont_done is sampled only in *_WAIT states, and never in the same cycle as mont_start.
  - mont_done held high across several cycles is consumed once: the WAIT state exits on the first high sample.
  - A mont_done that is still high when the next *_START is entered is not sampled in that START cycle.
- start while busy=1: ignored; latched operands unchanged.
- result holds its value until the next completion. It is not cleared by a new start.
- Operation count per exponent: in_e_len squares + popcount(E[in_e_len-1:0]) multiplies + 1 post-multiply.
  - in_e_len=0 gives 1 operation, and result = Mont(R mod M, 1) = 1 mod M.
- Exponent bits above in_e_len-1 are ignored.
- in_e_len > E_WIDTH is illegal (no defined behaviour).
- Latency: per operation, 1 START cycle + multiplier latency + 1 cycle. One extra cycle in NEXT per exponent bit.
- Reset asserted mid-operation aborts immediately to reset values. The multiplier sees no further mont_start.

Test Plan (bench uses the montgomery multiplier RTL or a behavioural model with random 1–40-cycle latency):
- M=13, x=5, e=3, in_e_len=2 (in_x/in_r precomputed with R=2^512): exactly 5 mont_start pulses; result=8; done high for 1 cycle; busy falls with done.
- in_e_len=0, any in_e: 1 mont_start pulse; result=1.
- 512-bit random M (odd), x, e=0b1011, in_e_len=4: 8 pulses in order S,M,S,S,M,S,M,P; result equals the Python x^11 mod M.
- Full-width 512-bit in_e (all ones), in_e_len=512: 1025 pulses; result matches golden; mont_a/b/m stable throughout every WAIT.
- start re-asserted every cycle while busy, and mont_done held high 3 cycles: no extra operations; latched operands unchanged; each mont_done consumed once.
- resetn=0 during MUL_WAIT: all outputs 0 immediately. A new start after release computes 5^3 mod 13 = 8 correctly.
